// File: rtl/rom_arb_pkg.sv
// Shared constants and types for the two-port ROM arbiter.
// Tag values name the port that owns an access as it moves through the pipeline.
package rom_arb_pkg;

    localparam logic TAG_A = 1'b0;
    localparam logic TAG_B = 1'b1;

    localparam int ROM_LATENCY    = 1;
    localparam int ARB_PIPE_DEPTH = 2;
    localparam int GNT_TO_RVALID  = ARB_PIPE_DEPTH + ROM_LATENCY;

    typedef enum logic {
        PORT_A = TAG_A,
        PORT_B = TAG_B
    } port_e;

endpackage

// File: rtl/rom_arbiter_rr_arb2.sv
// Two-input grant logic: round-robin or fixed A-priority, with the last-winner register.
// Grants are combinational; last_winner advances only when something is granted.
module rr_arb2
    import rom_arb_pkg::*;
#(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic a_req,
    input  logic b_req,
    output logic a_gnt,
    output logic b_gnt,
    output logic grant,
    output logic winner
);

    logic last_winner_reg;

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (a_req && b_req) begin
            // Under round-robin the port that did not win last time goes first.
            if (FIXED_PRIORITY || (last_winner_reg == TAG_B)) begin
                a_gnt = 1'b1;
            end else begin
                b_gnt = 1'b1;
            end
        end else begin
            a_gnt = a_req;
            b_gnt = b_req;
        end
    end

    assign grant  = a_gnt | b_gnt;
    assign winner = b_gnt ? TAG_B : TAG_A;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_winner_reg <= TAG_B;
        end else if (grant) begin
            last_winner_reg <= winner;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one registered-output byte ROM between a video port (A) and a CPU port (B).
// Each grant is tagged and followed through the ROM latency to a one-cycle rvalid.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 13,
    parameter int DATA_WIDTH     = 8,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  a_req,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    output logic                  a_gnt,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_rvalid,
    input  logic                  b_req,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic                  b_gnt,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_rvalid,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  busy
);

    localparam int LAST = ARB_PIPE_DEPTH - 1;

    logic                  grant;
    logic                  winner;
    logic [ADDR_WIDTH-1:0] grant_addr;

    logic [ADDR_WIDTH-1:0] rom_addr_reg;
    logic [LAST:0]         valid_reg;
    logic [LAST:0]         tag_reg;
    logic [DATA_WIDTH-1:0] a_rdata_reg;
    logic [DATA_WIDTH-1:0] b_rdata_reg;
    logic                  a_rvalid_reg;
    logic                  b_rvalid_reg;
    logic                  ret_a;
    logic                  ret_b;

    rr_arb2 #(
        .FIXED_PRIORITY(FIXED_PRIORITY)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .a_req   (a_req),
        .b_req   (b_req),
        .a_gnt   (a_gnt),
        .b_gnt   (b_gnt),
        .grant   (grant),
        .winner  (winner)
    );

    assign grant_addr = (winner == TAG_B) ? b_addr : a_addr;

    // The oldest stage lines up with the cycle rom_data holds that access's byte.
    assign ret_a = valid_reg[LAST] && (tag_reg[LAST] == TAG_A);
    assign ret_b = valid_reg[LAST] && (tag_reg[LAST] == TAG_B);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr_reg <= '0;
            valid_reg    <= '0;
            tag_reg      <= '0;
            a_rdata_reg  <= '0;
            b_rdata_reg  <= '0;
            a_rvalid_reg <= 1'b0;
            b_rvalid_reg <= 1'b0;
        end else begin
            if (grant) begin
                rom_addr_reg <= grant_addr;
            end
            valid_reg    <= {valid_reg[LAST-1:0], grant};
            tag_reg      <= {tag_reg[LAST-1:0], winner};
            a_rvalid_reg <= ret_a;
            b_rvalid_reg <= ret_b;
            if (ret_a) begin
                a_rdata_reg <= rom_data;
            end
            if (ret_b) begin
                b_rdata_reg <= rom_data;
            end
        end
    end

    assign rom_addr = rom_addr_reg;
    assign a_rdata  = a_rdata_reg;
    assign b_rdata  = b_rdata_reg;
    assign a_rvalid = a_rvalid_reg;
    assign b_rvalid = b_rvalid_reg;
    assign busy     = |valid_reg;

    a_gnt_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(a_gnt && b_gnt));
    gnt_needs_req: assert property (@(posedge clk) disable iff (!reset_n)
        (!a_gnt || a_req) && (!b_gnt || b_req));
    rvalid_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(a_rvalid && b_rvalid));

endmodule
